decode_issue_stage: RTL and testbench

//  IF/ID + ID/EX pipeline stage around the control ROM of the LC-3b pipeline. Latches the fetched

---
 rtl/lc3b_types.sv | 48 ++++
 rtl/hazard_detect.sv | 54 +++++
 rtl/decode_issue_stage.sv | 139 +++++++++++++
 tb/tb_decode_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, register specifier, opcodes and the control word.
// Pure declarations plus one helper; no logic, no latency.
// No flow control.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'ha,
    op_sti  = 4'hb,
    op_jmp  = 4'hc,
    op_shf  = 4'hd,
    op_lea  = 4'he,
    op_trap = 4'hf
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode  opcode;
    logic [2:0]  aluop;
    logic        load_cc;
    logic        load_regfile;
    logic        load_hazard;   // result only available after MEM
    logic        writemux_sel;  // 1: link register R7 is the destination
    logic        sr2mux_sel;
    logic        mem_read;
    logic        mem_write;
    logic        br_en;
  } lc3b_control_word;

  localparam lc3b_reg R7 = 3'd7;

  // Destination register written by an instruction in ID.
  function automatic lc3b_reg dest_of(input lc3b_control_word ctrl, input lc3b_word ir);
    return ctrl.writemux_sel ? R7 : ir[11:9];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: decodes which registers the ID instruction reads and compares with EX dest.
// Purely combinational, zero latency.
// No flow control; the result is consumed by the stage controller.
// Ports: id_ir_i/id_valid_i (ID instr), ex_valid_i/ex_ctrl_i/ex_dest_i (EX instr), load_use_o.
module hazard_detect
  import lc3b_types::*;
(
  input  logic             id_valid_i,
  input  lc3b_word         id_ir_i,
  input  logic             ex_valid_i,
  input  lc3b_control_word ex_ctrl_i,
  input  lc3b_reg          ex_dest_i,
  output logic             load_use_o
);

  logic       use_sr1;
  logic       use_sr2;
  logic       use_st;
  logic       src_match;
  lc3b_opcode op;

  assign op = lc3b_opcode'(id_ir_i[15:12]);

  always_comb begin
    use_sr1 = 1'b0;
    use_sr2 = 1'b0;
    use_st  = 1'b0;
    case (op)
      op_add, op_and: begin
        use_sr1 = 1'b1;
        use_sr2 = ~id_ir_i[5];  // immediate form reads no second register
      end
      op_not, op_shf, op_jmp, op_ldr, op_ldb, op_ldi: use_sr1 = 1'b1;
      op_str, op_stb, op_sti: begin
        use_sr1 = 1'b1;
        use_st  = 1'b1;
      end
      op_jsr: use_sr1 = ~id_ir_i[11];  // JSRR form reads the base register
      default: ;
    endcase
  end

  assign src_match = (use_sr1 && (id_ir_i[8:6]  == ex_dest_i)) ||
                     (use_sr2 && (id_ir_i[2:0]  == ex_dest_i)) ||
                     (use_st  && (id_ir_i[11:9] == ex_dest_i));

  assign load_use_o = id_valid_i & ex_valid_i & ex_ctrl_i.load_regfile &
                      ex_ctrl_i.load_hazard & src_match;

  // Only two control bits and part of the ID word matter here.
  logic unused_ok;
  assign unused_ok = ^{ex_ctrl_i, id_ir_i[4:3]};

endmodule

// File: rtl/decode_issue_stage.sv
// IF/ID + ID/EX stage around the LC-3b control ROM with load-use bubble insertion.
// Latency: fetch to EX register 2 cycles unstalled, 1 instr/cycle throughput.
// Backpressure: if_ready low on ex_stall, load-use hazard and pending bubbles; flush wins over all.
// Ports: clk/rst_n; fetch if_valid/if_ir/if_pc/if_ready; ROM id_opcode/id_ir4/5/11, ctrl_in;
//        control ex_stall/flush; EX ex_valid/ex_ctrl/ex_ir/ex_pc/ex_dest; debug load_use.
module decode_issue_stage
  import lc3b_types::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1  // 1..3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [15:0]      if_ir,
  input  logic [15:0]      if_pc,
  output logic             if_ready,
  output logic [3:0]       id_opcode,
  output logic             id_ir4,
  output logic             id_ir5,
  output logic             id_ir11,
  input  lc3b_control_word ctrl_in,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output lc3b_control_word ex_ctrl,
  output logic [15:0]      ex_ir,
  output logic [15:0]      ex_pc,
  output logic [2:0]       ex_dest,
  output logic             load_use
);

  // First hazard cycle already emits one bubble; the counter covers the rest.
  localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

  logic             id_valid_q, id_valid_d;
  lc3b_word         id_ir_q,    id_ir_d;
  lc3b_word         id_pc_q,    id_pc_d;
  logic             ex_valid_q, ex_valid_d;
  lc3b_control_word ex_ctrl_q,  ex_ctrl_d;
  lc3b_word         ex_ir_q,    ex_ir_d;
  lc3b_word         ex_pc_q,    ex_pc_d;
  lc3b_reg          ex_dest_q,  ex_dest_d;
  logic [1:0]       bubble_q,   bubble_d;
  logic             hazard_raw;
  logic             hazard;

  hazard_detect u_hazard_detect (
    .id_valid_i (id_valid_q),
    .id_ir_i    (id_ir_q),
    .ex_valid_i (ex_valid_q),
    .ex_ctrl_i  (ex_ctrl_q),
    .ex_dest_i  (ex_dest_q),
    .load_use_o (hazard_raw)
  );

  // While bubbles are still draining the hazard is not re-evaluated.
  assign hazard = hazard_raw & (bubble_q == 2'd0);

  always_comb begin
    id_valid_d = id_valid_q;
    id_ir_d    = id_ir_q;
    id_pc_d    = id_pc_q;
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_ir_d    = ex_ir_q;
    ex_pc_d    = ex_pc_q;
    ex_dest_d  = ex_dest_q;
    bubble_d   = bubble_q;
    if_ready   = 1'b1;

    if (flush) begin
      // Fetch is redirected; whatever it presents this cycle is dropped.
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      bubble_d   = 2'd0;
    end else if (ex_stall) begin
      if_ready = 1'b0;
    end else if (bubble_q != 2'd0) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      bubble_d   = bubble_q - 2'd1;
      if_ready   = 1'b0;
    end else if (hazard) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      bubble_d   = BUBBLE_RELOAD;
      if_ready   = 1'b0;
    end else begin
      ex_valid_d = id_valid_q;
      ex_ctrl_d  = id_valid_q ? ctrl_in : '0;
      ex_ir_d    = id_ir_q;
      ex_pc_d    = id_pc_q;
      ex_dest_d  = dest_of(ctrl_in, id_ir_q);
      id_valid_d = if_valid;
      if (if_valid) begin
        id_ir_d = if_ir;
        id_pc_d = if_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_ir_q    <= '0;
      id_pc_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_ir_q    <= '0;
      ex_pc_q    <= '0;
      ex_dest_q  <= '0;
      bubble_q   <= 2'd0;
    end else begin
      id_valid_q <= id_valid_d;
      id_ir_q    <= id_ir_d;
      id_pc_q    <= id_pc_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_ir_q    <= ex_ir_d;
      ex_pc_q    <= ex_pc_d;
      ex_dest_q  <= ex_dest_d;
      bubble_q   <= bubble_d;
    end
  end

  assign id_opcode = id_ir_q[15:12];
  assign id_ir4    = id_ir_q[4];
  assign id_ir5    = id_ir_q[5];
  assign id_ir11   = id_ir_q[11];

  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_ir     = ex_ir_q;
  assign ex_pc     = ex_pc_q;
  assign ex_dest   = ex_dest_q;
  assign load_use  = hazard;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: two instances (1 and 2 load-use bubbles).
// Instance 0 carries most scenarios; instance 1 covers the two-bubble and mid-bubble cases.
module tb_decode_issue_stage;
  import lc3b_types::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_stall;
  logic             flush;
  logic             if_valid  [2];
  logic [15:0]      if_ir     [2];
  logic [15:0]      if_pc     [2];
  logic             if_ready  [2];
  logic [3:0]       id_opcode [2];
  logic             id_ir4    [2];
  logic             id_ir5    [2];
  logic             id_ir11   [2];
  lc3b_control_word ctrl_in   [2];
  logic             ex_valid  [2];
  lc3b_control_word ex_ctrl   [2];
  logic [15:0]      ex_ir     [2];
  logic [15:0]      ex_pc     [2];
  logic [2:0]       ex_dest   [2];
  logic             load_use  [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Reference control ROM.
  function automatic lc3b_control_word rom(input logic [15:0] ir);
    lc3b_control_word c;
    c = '0;
    case (lc3b_opcode'(ir[15:12]))
      op_add: begin c.load_regfile = 1; c.load_cc = 1; c.sr2mux_sel = ir[5]; c.aluop = 3'd0; end
      op_and: begin c.load_regfile = 1; c.load_cc = 1; c.sr2mux_sel = ir[5]; c.aluop = 3'd1; end
      op_not: begin c.load_regfile = 1; c.load_cc = 1; c.aluop = 3'd2; end
      op_shf: begin c.load_regfile = 1; c.load_cc = 1; c.aluop = {2'b01, ir[4]}; end
      op_lea: begin c.load_regfile = 1; c.load_cc = 1; end
      op_ldr, op_ldb, op_ldi: begin
        c.load_regfile = 1; c.load_cc = 1; c.load_hazard = 1; c.mem_read = 1;
      end
      op_str, op_stb, op_sti: c.mem_write = 1;
      op_jsr, op_trap: begin c.load_regfile = 1; c.writemux_sel = 1; end
      op_br, op_jmp: c.br_en = 1;
      default: c = '0;
    endcase
    if (c != '0) c.opcode = lc3b_opcode'(ir[15:12]);
    return c;
  endfunction

  assign ctrl_in[0] = rom({id_opcode[0], id_ir11[0], 5'b0, id_ir5[0], id_ir4[0], 4'b0});
  assign ctrl_in[1] = rom({id_opcode[1], id_ir11[1], 5'b0, id_ir5[1], id_ir4[1], 4'b0});

  decode_issue_stage #(.LOAD_USE_BUBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid[0]), .if_ir(if_ir[0]), .if_pc(if_pc[0]),
    .if_ready(if_ready[0]), .id_opcode(id_opcode[0]), .id_ir4(id_ir4[0]), .id_ir5(id_ir5[0]),
    .id_ir11(id_ir11[0]), .ctrl_in(ctrl_in[0]), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid[0]), .ex_ctrl(ex_ctrl[0]), .ex_ir(ex_ir[0]), .ex_pc(ex_pc[0]),
    .ex_dest(ex_dest[0]), .load_use(load_use[0])
  );

  decode_issue_stage #(.LOAD_USE_BUBBLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid[1]), .if_ir(if_ir[1]), .if_pc(if_pc[1]),
    .if_ready(if_ready[1]), .id_opcode(id_opcode[1]), .id_ir4(id_ir4[1]), .id_ir5(id_ir5[1]),
    .id_ir11(id_ir11[1]), .ctrl_in(ctrl_in[1]), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid[1]), .ex_ctrl(ex_ctrl[1]), .ex_ir(ex_ir[1]), .ex_pc(ex_pc[1]),
    .ex_dest(ex_dest[1]), .load_use(load_use[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch word and let combinational outputs settle before checking.
  task automatic set_if(input int d, input logic v, input logic [15:0] ir, input logic [15:0] pc);
    if_valid[d] = v;
    if_ir[d]    = ir;
    if_pc[d]    = pc;
    #1;
  endtask

  // LDR R1,R2,#0 then ADD R3,R1,R1; ends in the cycle the hazard is flagged.
  task automatic lu_head(input int d);
    set_if(d, 1, 16'h6280, 16'h5002);
    tick();
    set_if(d, 1, 16'h1641, 16'h5004);
    check("lu_pre_load_use", 32'(load_use[d]), 0);
    check("lu_pre_ready", 32'(if_ready[d]), 1);
    tick();
    set_if(d, 1, 16'h16a1, 16'h5006);
    check("lu_detect", 32'(load_use[d]), 1);
    check("lu_ready_low", 32'(if_ready[d]), 0);
    check("lu_ex_ldr", 32'(ex_ir[d]), 32'h6280);
    check("lu_ex_dest", 32'(ex_dest[d]), 1);
    tick();
  endtask

  task automatic run_lu(input int d, input int nb);
    lu_head(d);
    for (int b = 1; b < nb; b++) begin
      check("lu_bubble_valid", 32'(ex_valid[d]), 0);
      check("lu_bubble_ready", 32'(if_ready[d]), 0);
      check("lu_bubble_redetect", 32'(load_use[d]), 0);
      tick();
    end
    check("lu_last_bubble_valid", 32'(ex_valid[d]), 0);
    check("lu_last_bubble_ctrl", 32'(ex_ctrl[d]), 0);
    check("lu_resume_ready", 32'(if_ready[d]), 1);
    check("lu_resume_load_use", 32'(load_use[d]), 0);
    tick();
    set_if(d, 0, 16'h0000, 16'h0000);
    check("lu_add_in_ex", 32'(ex_ir[d]), 32'h1641);
    check("lu_add_valid", 32'(ex_valid[d]), 1);
    check("lu_add_dest", 32'(ex_dest[d]), 3);
    tick();
    check("lu_next_in_ex", 32'(ex_ir[d]), 32'h16a1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_valid[i] = 1'b0; if_ir[i] = '0; if_pc[i] = '0;
    end
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state and T1: ADD R1,R2,R3 then AND R4,R1,#5.
    set_if(0, 1, 16'h1283, 16'h3002);
    check("rst_ex_valid", 32'(ex_valid[0]), 0);
    check("rst_ex_ctrl", 32'(ex_ctrl[0]), 0);
    check("rst_ex_ir", 32'(ex_ir[0]), 0);
    check("rst_ex_pc", 32'(ex_pc[0]), 0);
    check("rst_ex_dest", 32'(ex_dest[0]), 0);
    check("rst_if_ready", 32'(if_ready[0]), 1);
    tick();
    set_if(0, 1, 16'h5865, 16'h3004);
    check("t1_ready1", 32'(if_ready[0]), 1);
    check("t1_ex_empty", 32'(ex_valid[0]), 0);
    tick();
    set_if(0, 0, 16'h0000, 16'h0000);
    check("t1_add_ir", 32'(ex_ir[0]), 32'h1283);
    check("t1_add_pc", 32'(ex_pc[0]), 32'h3002);
    check("t1_add_valid", 32'(ex_valid[0]), 1);
    check("t1_add_dest", 32'(ex_dest[0]), 1);
    check("t1_add_ctrl", 32'(ex_ctrl[0]), 32'(rom(16'h1283)));
    check("t1_ready2", 32'(if_ready[0]), 1);
    tick();
    check("t1_and_ir", 32'(ex_ir[0]), 32'h5865);
    check("t1_and_dest", 32'(ex_dest[0]), 4);
    check("t1_and_ctrl", 32'(ex_ctrl[0]), 32'(rom(16'h5865)));
    tick();
    check("t1_drain_valid", 32'(ex_valid[0]), 0);
    check("t1_drain_ctrl", 32'(ex_ctrl[0]), 0);

    // T2 / T3: load-use with one and two bubbles.
    run_lu(0, 1);
    run_lu(1, 2);

    // T4: independent ADD after LDR, JSR to R7, unknown opcode.
    set_if(0, 1, 16'h6280, 16'h6002);
    tick();
    set_if(0, 1, 16'h16a1, 16'h6004);
    tick();
    set_if(0, 1, 16'h4800, 16'h6006);
    check("t4_no_hazard", 32'(load_use[0]), 0);
    check("t4_ready", 32'(if_ready[0]), 1);
    tick();
    set_if(0, 1, 16'h8000, 16'h6008);
    check("t4_add_ir", 32'(ex_ir[0]), 32'h16a1);
    check("t4_add_dest", 32'(ex_dest[0]), 3);
    tick();
    set_if(0, 0, 16'h0000, 16'h0000);
    check("t4_jsr_ir", 32'(ex_ir[0]), 32'h4800);
    check("t4_jsr_dest", 32'(ex_dest[0]), 7);
    tick();
    check("t4_unk_ir", 32'(ex_ir[0]), 32'h8000);
    check("t4_unk_valid", 32'(ex_valid[0]), 1);
    check("t4_unk_ctrl", 32'(ex_ctrl[0]), 0);
    tick();

    // T5: three-cycle stall mid-stream.
    set_if(0, 1, 16'h1283, 16'h7002);
    tick();
    set_if(0, 1, 16'h1483, 16'h7004);
    tick();
    ex_stall = 1'b1;
    set_if(0, 1, 16'h1683, 16'h7006);
    for (int s = 0; s < 3; s++) begin
      check("t5_stall_ex_ir", 32'(ex_ir[0]), 32'h1283);
      check("t5_stall_ready", 32'(if_ready[0]), 0);
      tick();
    end
    ex_stall = 1'b0;
    #1;
    check("t5_release_ex_ir", 32'(ex_ir[0]), 32'h1283);
    check("t5_release_ready", 32'(if_ready[0]), 1);
    tick();
    set_if(0, 1, 16'h1883, 16'h7008);
    check("t5_b_ir", 32'(ex_ir[0]), 32'h1483);
    tick();
    set_if(0, 0, 16'h0000, 16'h0000);
    check("t5_c_ir", 32'(ex_ir[0]), 32'h1683);
    tick();
    check("t5_d_ir", 32'(ex_ir[0]), 32'h1883);
    check("t5_d_dest", 32'(ex_dest[0]), 4);
    tick();
    check("t5_end_valid", 32'(ex_valid[0]), 0);

    // T6a: flush with valid ID and EX, concurrent with stall.
    set_if(0, 1, 16'h1283, 16'h8002);
    tick();
    set_if(0, 1, 16'h1483, 16'h8004);
    tick();
    flush = 1'b1; ex_stall = 1'b1;
    set_if(0, 1, 16'h1683, 16'h8006);
    check("t6_pre_ex_valid", 32'(ex_valid[0]), 1);
    check("t6_flush_ready", 32'(if_ready[0]), 1);
    tick();
    flush = 1'b0; ex_stall = 1'b0;
    set_if(0, 0, 16'h0000, 16'h0000);
    check("t6_ex_squashed", 32'(ex_valid[0]), 0);
    check("t6_ctrl_cleared", 32'(ex_ctrl[0]), 0);
    tick();
    check("t6_id_squashed", 32'(ex_valid[0]), 0);

    // T6b: flush + stall while a bubble is pending (two-bubble instance).
    lu_head(1);
    flush = 1'b1; ex_stall = 1'b1;
    set_if(1, 1, 16'h1883, 16'h9008);
    check("t6b_flush_ready", 32'(if_ready[1]), 1);
    tick();
    flush = 1'b0; ex_stall = 1'b0;
    #1;
    check("t6b_ex_valid", 32'(ex_valid[1]), 0);
    check("t6b_bubble_cleared", 32'(if_ready[1]), 1);
    check("t6b_no_hazard", 32'(load_use[1]), 0);
    tick();
    set_if(1, 0, 16'h0000, 16'h0000);
    check("t6b_id_squashed", 32'(ex_valid[1]), 0);
    tick();
    check("t6b_new_valid", 32'(ex_valid[1]), 1);
    check("t6b_new_ir", 32'(ex_ir[1]), 32'h1883);
    tick();

    // Reset pulse mid-stream on instance 0 and mid-bubble on instance 1.
    set_if(0, 1, 16'h1283, 16'ha002);
    tick();
    set_if(0, 1, 16'h1483, 16'ha004);
    lu_head(1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_if(0, 0, 16'h0000, 16'h0000);
    set_if(1, 0, 16'h0000, 16'h0000);
    check("rst2_ex_valid", 32'(ex_valid[0]), 0);
    check("rst2_ex_ir", 32'(ex_ir[0]), 0);
    check("rst2_ex_pc", 32'(ex_pc[0]), 0);
    check("rst2_ex_dest", 32'(ex_dest[0]), 0);
    check("rst2_ex_ctrl", 32'(ex_ctrl[0]), 0);
    check("rst2_ready", 32'(if_ready[0]), 1);
    check("rst2_bubble_ready", 32'(if_ready[1]), 1);
    check("rst2_bubble_valid", 32'(ex_valid[1]), 0);
    tick();
    check("rst2_id_cleared", 32'(ex_valid[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
